mdu_hilo: RTL and testbench

- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the general register file: it consumes the two register read ports (rs/rt values) for mult/multu/div/divu, and serves mfhi/mflo/mthi/mtlo.
- Models fixed-latency iterative hardware with a busy flag, so the control unit can stall dependent HI/LO instructions.

---
 rtl/mdu_hilo.sv | 109 ++++++++++
 tb/tb_mdu_hilo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// Iterative-latency multiply/divide unit holding the architectural HI/LO pair.
// Operands are captured on start; HI/LO update when the busy countdown expires.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mt_we,
    input  logic        mt_hi,
    input  logic [31:0] mt_data,
    input  logic        mf_hi,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [3:0]  count;
    logic [1:0]  op_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    logic        is_signed;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] uquo;
    logic [31:0] urem;
    logic [31:0] quo;
    logic [31:0] rem;

    // Results are formed from the captured operands; the countdown only models latency.
    // Signed division works on magnitudes so 0x80000000 / -1 needs no special case.
    always_comb begin
        is_signed = ~op_reg[0];
        ext_a     = {(is_signed ? {32{a_reg[31]}} : 32'h0), a_reg};
        ext_b     = {(is_signed ? {32{b_reg[31]}} : 32'h0), b_reg};
        product   = ext_a * ext_b;
        abs_a     = (is_signed && a_reg[31]) ? (32'h0 - a_reg) : a_reg;
        abs_b     = (is_signed && b_reg[31]) ? (32'h0 - b_reg) : b_reg;
        uquo      = 32'h0;
        urem      = 32'h0;
        if (abs_b != 32'h0) begin
            uquo = abs_a / abs_b;
            urem = abs_a % abs_b;
        end
        quo = (is_signed && (a_reg[31] ^ b_reg[31])) ? (32'h0 - uquo) : uquo;
        rem = (is_signed && a_reg[31]) ? (32'h0 - urem) : urem;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= 4'd0;
            op_reg <= 2'b00;
            a_reg  <= 32'h0;
            b_reg  <= 32'h0;
            hi_reg <= 32'h0;
            lo_reg <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_reg <= op;
                        a_reg  <= rs_val;
                        b_reg  <= rt_val;
                        count  <= op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        state  <= RUN;
                    end else if (mt_we) begin
                        if (mt_hi) hi_reg <= mt_data;
                        else       lo_reg <= mt_data;
                    end
                end
                RUN: begin
                    count <= count - 4'd1;
                    // A zero divisor still burns the full latency but leaves HI/LO alone.
                    if (count == 4'd1) begin
                        state <= IDLE;
                        if (!op_reg[1]) begin
                            hi_reg <= product[63:32];
                            lo_reg <= product[31:0];
                        end else if (b_reg != 32'h0) begin
                            hi_reg <= rem;
                            lo_reg <= quo;
                        end
                    end
                end
            endcase
        end
    end

    assign busy    = (state == RUN);
    assign hi      = hi_reg;
    assign lo      = lo_reg;
    assign mf_data = mf_hi ? hi_reg : lo_reg;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed vector table, hazard/reset sequences,
// and randomized operations checked against a plain-arithmetic reference model.
module tb_mdu_hilo;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    localparam int LIMIT  = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mt_we;
    logic        mt_hi;
    logic [31:0] mt_data;
    logic        mf_hi;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_data;

    int total = 0;
    int bad   = 0;

    mdu_hilo #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .mt_we(mt_we), .mt_hi(mt_hi),
        .mt_data(mt_data), .mf_hi(mf_hi), .busy(busy), .hi(hi), .lo(lo),
        .mf_data(mf_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  vop;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one start pulse, then scramble the operand buses to prove capture-on-start.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        tick();
        start  = 1'b0;
        rs_val = $urandom;
        rt_val = $urandom;
    endtask

    task automatic waitDone(input int already, output int cycles);
        cycles = already;
        while (busy === 1'b1 && cycles < LIMIT) begin
            cycles++;
            tick();
        end
    endtask

    task automatic mtWrite(input logic sel_hi, input logic [31:0] d);
        mt_we   = 1'b1;
        mt_hi   = sel_hi;
        mt_data = d;
        tick();
        mt_we   = 1'b0;
    endtask

    function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] prev);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        r  = prev;
        case (o)
            2'b00: r = sa * sb;
            2'b01: r = ua * ub;
            2'b10: if (b != 32'h0) begin
                sq = sa / sb;
                sr = sa % sb;
                r  = {sr[31:0], sq[31:0]};
            end
            default: if (b != 32'h0) begin
                ua = ua / ub + ((ua % ub) << 32);
                r  = ua;
            end
        endcase
        return r;
    endfunction

    vec_t vecs[8];

    initial begin
        int          cyc;
        logic [63:0] model;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[6] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

        reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = 32'h0; rt_val = 32'h0;
        mt_we = 1'b0; mt_hi = 1'b0; mt_data = 32'h0; mf_hi = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        checkOutput("reset_hi", hi, 32'h0);
        checkOutput("reset_lo", lo, 32'h0);

        mtWrite(1'b1, 32'h12345678);
        mtWrite(1'b0, 32'h9ABCDEF0);
        checkOutput("mthi", hi, 32'h12345678);
        checkOutput("mtlo", lo, 32'h9ABCDEF0);
        mf_hi = 1'b1; #1;
        checkOutput("mf_hi", mf_data, 32'h12345678);
        mf_hi = 1'b0; #1;
        checkOutput("mf_lo", mf_data, 32'h9ABCDEF0);

        // Consecutive vectors start in the first non-busy cycle, exercising back-to-back issue.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].vop, vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d_busy_rise", i), {31'h0, busy}, 32'h1);
            waitDone(0, cyc);
            checkOutput($sformatf("vec%0d_busy_cycles", i), 32'(cyc),
                        vecs[i].vop[1] ? 32'(DIV_N) : 32'(MULT_N));
            checkOutput($sformatf("vec%0d_hi", i), hi, vecs[i].ehi);
            checkOutput($sformatf("vec%0d_lo", i), lo, vecs[i].elo);
        end

        mtWrite(1'b1, 32'hAAAA0000);
        mtWrite(1'b0, 32'h0000BBBB);
        applyStimulus(2'b11, 32'h00001234, 32'h0);
        waitDone(0, cyc);
        checkOutput("div0_busy_cycles", 32'(cyc), 32'(DIV_N));
        checkOutput("div0_hi", hi, 32'hAAAA0000);
        checkOutput("div0_lo", lo, 32'h0000BBBB);
        applyStimulus(2'b10, 32'h00001234, 32'h0);
        waitDone(0, cyc);
        checkOutput("sdiv0_hi", hi, 32'hAAAA0000);
        checkOutput("sdiv0_lo", lo, 32'h0000BBBB);

        applyStimulus(2'b00, 32'h00000003, 32'h00000005);
        tick();
        start = 1'b1; op = 2'b11; rs_val = 32'd100; rt_val = 32'd7;
        mt_we = 1'b1; mt_hi = 1'b0; mt_data = 32'hDEADBEEF;
        tick();
        start = 1'b0; mt_we = 1'b0;
        waitDone(2, cyc);
        checkOutput("hazard_busy_cycles", 32'(cyc), 32'(MULT_N));
        checkOutput("hazard_hi", hi, 32'h0);
        checkOutput("hazard_lo", lo, 32'd15);
        tick();
        checkOutput("hazard_no_restart", {31'h0, busy}, 32'h0);

        mtWrite(1'b1, 32'h11111111);
        applyStimulus(2'b00, 32'h00000009, 32'h00000009);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midreset_busy", {31'h0, busy}, 32'h0);
        checkOutput("midreset_hi", hi, 32'h0);
        checkOutput("midreset_lo", lo, 32'h0);
        repeat (12) tick();
        checkOutput("midreset_late_hi", hi, 32'h0);
        checkOutput("midreset_late_lo", lo, 32'h0);
        checkOutput("midreset_late_busy", {31'h0, busy}, 32'h0);

        mtWrite(1'b1, 32'h5A5A5A5A);
        mtWrite(1'b0, 32'hA5A5A5A5);
        model = {32'h5A5A5A5A, 32'hA5A5A5A5};
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000000F;
            if (ro[1] && $urandom_range(0, 7) == 0) rb = 32'h0;
            if ($urandom_range(0, 9) == 0) ra = 32'h80000000;
            if ($urandom_range(0, 9) == 0) rb = 32'hFFFFFFFF;
            model = refModel(ro, ra, rb, model);
            applyStimulus(ro, ra, rb);
            waitDone(0, cyc);
            checkOutput($sformatf("rnd%0d_op%0d_busy_cycles", i, ro), 32'(cyc),
                        ro[1] ? 32'(DIV_N) : 32'(MULT_N));
            checkOutput($sformatf("rnd%0d_op%0d_%h_%h_hi", i, ro, ra, rb), hi, model[63:32]);
            checkOutput($sformatf("rnd%0d_op%0d_%h_%h_lo", i, ro, ra, rb), lo, model[31:0]);
            mf_hi = ra[0]; #1;
            checkOutput($sformatf("rnd%0d_mf", i), mf_data, ra[0] ? model[63:32] : model[31:0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
